wb_master_arbiter: RTL
======================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of Wishbone masters sharing one slave port (legal 2..8).
REQ-002 Parameter TIMEOUT, default 1023, max wait cycles for ack/err before abort (legal 1..65535).
REQ-003 wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 m_cyc_i / m_stb_i / m_we_i  input  NUM_MASTERS each  per-master cycle, strobe, write-enable; bit i belongs to master i.
REQ-006 m_sel_i  input  4*NUM_MASTERS  byte selects, master i at [4i+3:4i].
REQ-007 m_adr_i, m_dat_i  input  32*NUM_MASTERS each  address and write data, master i at [32i+31:32i].
REQ-008 m_dat_o  output  32  read data, broadcast to all masters.
REQ-009 m_ack_o, m_err_o  output  NUM_MASTERS each  per-master acknowledge / error.
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side cycle, strobe, write-enable.
REQ-011 s_sel_o  output  4; s_adr_o, s_dat_o  output  32 each  slave-side selects, address, write data.
REQ-012 s_dat_i  input  32; s_ack_i, s_err_i  input  1 each  slave read data, acknowledge, error.
REQ-013 grant_o  output  NUM_MASTERS  one-hot current grant, all-zero when idle.
REQ-014 timeout_o  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 FSM SHALL have three states: IDLE, BUSY, ABORT.
REQ-016 Request from master i = m_cyc_i[i] & m_stb_i[i].
REQ-017 In IDLE with at least one request, SHALL enter BUSY next edge, grant_o registering the winner one-hot; no request -> stay IDLE.
REQ-018 Arbitration SHALL be round-robin: search from last_grant+1 upward, wrapping modulo NUM_MASTERS; first requester wins.
REQ-019 last_grant SHALL update to the winner on the IDLE->BUSY edge only.
REQ-020 In BUSY, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow the granted master's inputs.
REQ-021 In IDLE and ABORT, s_cyc_o and s_stb_o SHALL be 0; other slave outputs don't-care.
REQ-022 m_dat_o SHALL equal s_dat_i at all times.
REQ-023 In BUSY, m_ack_o/m_err_o for the granted master SHALL equal s_ack_i/s_err_i combinationally; all other bits 0; both all-zero outside BUSY except REQ-027.
REQ-024 Grant SHALL be held in BUSY while the granted m_cyc_i stays high (multi-beat cycles permitted); requests from other masters are ignored.
REQ-025 BUSY SHALL go to IDLE on the edge where granted m_cyc_i is sampled low; re-arbitration occurs from IDLE, so minimum one idle cycle between grants.
REQ-026 Timeout counter (16 bit) SHALL clear on entering BUSY and whenever s_ack_i or s_err_i is high, increment each BUSY cycle with s_stb_o high and no ack/err, and hold when s_stb_o low.
REQ-027 Counter reaching TIMEOUT in BUSY SHALL: move to ABORT next edge, assert m_err_o[grant] and timeout_o for exactly that first ABORT cycle.
REQ-028 ABORT SHALL keep grant_o and hold until granted m_cyc_i is sampled low, then go to IDLE.
REQ-029 s_ack_i/s_err_i arriving in the same cycle the counter reaches TIMEOUT SHALL take priority: ack/err delivered, counter cleared, no abort.
REQ-030 Master dropping m_cyc_i mid-wait SHALL end the slave cycle immediately (combinational follow) and return to IDLE next edge without error.
REQ-031 Slave ack/err outside BUSY SHALL be ignored.

Reset
REQ-032 wb_rst_n_i low SHALL asynchronously force IDLE, grant_o=0, last_grant=NUM_MASTERS-1, counter=0, timeout_o=0, so master 0 has first priority.
REQ-033 Reset asserted mid-BUSY SHALL immediately drop s_cyc_o/s_stb_o and all m_ack_o/m_err_o; no transaction is resumed after release.
REQ-034 Release SHALL be sampled synchronously; first arbitration on the first edge after deassertion.

Verification
REQ-035 Single request: master 1 writes adr 0x10, dat 0xDEADBEEF, slave acks after 3 cycles -> grant_o=2'b10 one cycle after request, s_adr_o=0x10, m_ack_o=2'b10 for one cycle, IDLE after cyc drop.
REQ-036 Round-robin: both masters request continuously from reset -> grants alternate 01,10,01,10 with one idle cycle between.
REQ-037 Timeout: TIMEOUT=8, slave never acks -> timeout_o and m_err_o[grant] pulse once after 8 stalled strobe cycles, s_cyc_o low from then, IDLE after master drops cyc.
REQ-038 Ack on boundary: ack in the exact cycle counter hits TIMEOUT -> m_ack_o asserted, no timeout_o, no m_err_o.
REQ-039 Read path: master 0 reads, slave returns 0x12345678 with ack -> m_dat_o=0x12345678 during m_ack_o[0].
REQ-040 Reset mid-cycle: assert wb_rst_n_i during BUSY -> s_cyc_o=0 and grant_o=0 same cycle, master 0 wins first post-reset arbitration when both request.

Source files
------------

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between the shared-slave arbiter, its masters and the slave.
// Per-master fields are flat vectors: master i owns bit i, sel[4i+3:4i],
// adr/dat[32i+31:32i].
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [32*NUM_MASTERS-1:0] m_adr_i, m_dat_i;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o, m_err_o;
  logic                      s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]                s_sel_o;
  logic [31:0]               s_adr_o, s_dat_o;
  logic [31:0]               s_dat_i;
  logic                      s_ack_i, s_err_i;

  // Arbiter view: it acts as the single Wishbone master on the slave port.
  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  // Environment view: masters and slave driving the arbiter.
  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters,
// with a stall watchdog that aborts a transaction with an error after
// TIMEOUT unacknowledged strobe cycles.
module wb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_master_arbiter_if.master    bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  logic [NUM_MASTERS-1:0] req;
  logic [IW-1:0]          win;
  logic                   win_vld;
  logic                   busy, s_resp, tmo_hit;

  // Per-master slices, so the granted master can be selected by index.
  logic [3:0]  sel_a [NUM_MASTERS];
  logic [31:0] adr_a [NUM_MASTERS];
  logic [31:0] dat_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
    assign sel_a[g] = bus.m_sel_i[4*g +: 4];
    assign adr_a[g] = bus.m_adr_i[32*g +: 32];
    assign dat_a[g] = bus.m_dat_i[32*g +: 32];
  end

  assign req     = bus.m_cyc_i & bus.m_stb_i;
  assign busy    = (state_q == BUSY);
  assign s_resp  = bus.s_ack_i | bus.s_err_i;
  // The check uses the registered count: TIMEOUT full stalled cycles must
  // elapse before the abort decision, and an ack in that cycle still wins.
  assign tmo_hit = (cnt_q == 16'(TIMEOUT));

  // Round-robin pick: first requester searching upward from last_grant+1.
  always_comb begin : rr_pick
    logic [IW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_MASTERS);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // last_q always names the granted master while BUSY/ABORT, so it drives
  // the slave-side mux directly; cyc/stb are gated to zero outside BUSY.
  assign bus.s_cyc_o = busy & bus.m_cyc_i[last_q];
  assign bus.s_stb_o = busy & bus.m_stb_i[last_q];
  assign bus.s_we_o  = bus.m_we_i[last_q];
  assign bus.s_sel_o = sel_a[last_q];
  assign bus.s_adr_o = adr_a[last_q];
  assign bus.s_dat_o = dat_a[last_q];

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = busy ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
  assign bus.m_err_o = (busy  ? (grant_q & {NUM_MASTERS{bus.s_err_i}}) : '0)
                     | (tmo_q ? grant_q : '0);

  assign grant_o   = grant_q;
  assign timeout_o = tmo_q;

  // Next-state logic: arbitration, grant hold, watchdog and abort.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!bus.m_cyc_i[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_resp) begin
          cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = ABORT;
          tmo_d   = 1'b1;
        end else if (bus.s_stb_o) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ABORT: begin
        if (!bus.m_cyc_i[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves master 0 with first priority.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule
